// File: rtl/disp_mux_n_if.sv
// Bus between display-formatting logic (master) and the digit multiplexer
// (slave): per-digit segment bytes, blanking and brightness in; anode and
// segment drive plus slot/frame status out.
interface disp_mux_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [8*NUM_DIGITS-1:0] din;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              sseg;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_tick;

  modport master (
    output din, blank_mask, brightness,
    input  an, sseg, digit_idx, frame_tick
  );

  modport slave (
    input  din, blank_mask, brightness,
    output an, sseg, digit_idx, frame_tick
  );
endinterface

// File: rtl/disp_mux_n.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment + DP display.
// Each slot is 2**PRESCALE_W cycles long: the digit's inputs are captured at
// the slot start, anodes stay off for GUARD cycles, then the digit is lit
// according to a PWM duty derived from the top prescaler bits.
module disp_mux_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE_W = 16,
  parameter int BRIGHT_W   = 4,
  parameter int GUARD      = 4
) (
  input logic       clk,
  input logic       reset,
  disp_mux_n_if.slave bus
);
  localparam int                   IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESCALE_W-1:0] GUARD_CNT = PRESCALE_W'(GUARD);

  logic [PRESCALE_W-1:0] pre;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  wrap;
  logic [7:0]            snap_seg;
  logic                  snap_blank;
  logic [BRIGHT_W-1:0]   snap_bri;
  logic [BRIGHT_W-1:0]   phase;
  logic                  lit;
  logic [NUM_DIGITS-1:0] onehot;

  // Slot boundary detection, next digit, PWM phase and lit decision.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wrap     = &pre;
    idx_next = idx;
    if (wrap) begin
      // Explicit wrap so non-power-of-two digit counts never reach NUM_DIGITS.
      idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
    phase  = pre[PRESCALE_W-1 -: BRIGHT_W];
    lit    = !snap_blank && (pre >= GUARD_CNT) &&
             ((phase < snap_bri) || (&snap_bri));
    onehot = NUM_DIGITS'(1) << idx;
  end

  // Prescaler, digit counter and per-slot input snapshot.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      snap_seg   <= '0;
      snap_blank <= 1'b1;
      snap_bri   <= '0;
    end else begin
      pre <= pre + PRESCALE_W'(1);
      idx <= idx_next;
      if (wrap) begin
        snap_seg   <= bus.din[{idx_next, 3'b000} +: 8];
        snap_blank <= bus.blank_mask[idx_next];
        snap_bri   <= bus.brightness;
      end
    end
  end

  // Registered pin drive, one cycle behind the state above.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an         <= '1;
      bus.sseg       <= 8'hFF;
      bus.digit_idx  <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= lit ? ~onehot : '1;
      bus.sseg       <= lit ? snap_seg : 8'hFF;
      bus.digit_idx  <= idx;
      bus.frame_tick <= wrap && (idx == LAST_IDX);
    end
  end
endmodule
